// File: rtl/stoplight_pkg.sv
// rtl/stoplight_pkg.sv - light encodings and request FSM states shared with the stoplight controller
package stoplight_pkg;

  localparam logic [2:0] RED = 3'b001;
  localparam logic [2:0] YLW = 3'b010;
  localparam logic [2:0] GRN = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    SERVE = 2'd2
  } req_state_e;

endpackage

// File: rtl/sensor_debounce.sv
// rtl/sensor_debounce.sv - two-flop synchronizer plus consecutive-sample debounce
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic sensor_raw,
  output logic debounced
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any sample agreeing with the current level restarts qualification.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_MAX) begin
        deb_d = ~deb_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sensor_raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign debounced = deb_q;

endmodule

// File: rtl/car_sensor_conditioner.sv
// rtl/car_sensor_conditioner.sv - latched car request with service detection and wait counter
module car_sensor_conditioner
  import stoplight_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3,
  parameter int WAIT_W          = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sensor_raw,
  input  logic [2:0]        light_pros,
  output logic              car_present,
  output logic              car_debounced,
  output logic [WAIT_W-1:0] wait_cycles
);

  logic              deb;
  req_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  sensor_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .sensor_raw(sensor_raw),
    .debounced (deb)
  );

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: begin
        if (deb) begin
          state_d = REQ;
          wait_d  = '0;
        end
      end
      REQ: begin
        // The request is held even if the car leaves; only green releases it.
        if (wait_q != {WAIT_W{1'b1}}) wait_d = wait_q + WAIT_W'(1);
        if (light_pros == GRN) state_d = SERVE;
      end
      SERVE: begin
        if (light_pros != GRN) begin
          if (deb) begin
            state_d = REQ;
            wait_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign car_present   = (state_q == REQ);
  assign car_debounced = deb;
  assign wait_cycles   = wait_q;

endmodule
